// File: rtl/io_mux_matrix_pkg.sv
// Shared definitions for the parametrised pad multiplexer.
package io_mux_matrix_pkg;

  // Width of the pin-index config address
  localparam int unsigned CFG_ADDR_W = 6;

  // Per-pin turnaround FSM states
  typedef enum logic {
    PIN_TURN   = 1'b0,
    PIN_ACTIVE = 1'b1
  } pin_state_e;

  // Bit width able to hold n-1, never narrower than one bit
  function automatic int unsigned width_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_mux_matrix_pin.sv
// One pad: input synchroniser, target select, break-before-make turnaround FSM and muxes.
module io_mux_matrix_pin
  import io_mux_matrix_pkg::*;
#(
  parameter int unsigned FUNC_COUNT   = 4,
  parameter int unsigned SEL_WIDTH    = 2,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TURNAROUND   = 4,
  parameter logic [SEL_WIDTH-1:0]  DEFAULT_SEL  = '0,
  parameter logic [FUNC_COUNT-1:0] FUNC_IDLE_IN = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [SEL_WIDTH-1:0]  i_wdata,
  output logic [SEL_WIDTH-1:0]  o_target,
  output logic                  o_switching,
  input  logic [FUNC_COUNT-1:0] i_func_out,
  input  logic [FUNC_COUNT-1:0] i_func_oe,
  output logic [FUNC_COUNT-1:0] o_func_in,
  input  logic                  i_io_in,
  output logic                  o_io_out,
  output logic                  o_io_oeb
);

  localparam int unsigned CNT_W = width_min1(TURNAROUND);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TURNAROUND - 1);

  pin_state_e             r_state;
  logic [SEL_WIDTH-1:0]   r_target;
  logic [CNT_W-1:0]       r_count;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_q;

  // Pad input synchroniser, free-running in both FSM states
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_io_in};
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // Turnaround FSM: any write during TURN restarts the hi-Z window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= PIN_TURN;
      r_target <= DEFAULT_SEL;
      r_count  <= CNT_INIT;
    end else begin
      case (r_state)
        PIN_TURN: begin
          if (i_we) begin
            r_target <= i_wdata;
            r_count  <= CNT_INIT;
          end else if (r_count == '0) begin
            r_state <= PIN_ACTIVE;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        PIN_ACTIVE: begin
          if (i_we && (i_wdata != r_target)) begin
            r_target <= i_wdata;
            r_state  <= PIN_TURN;
            r_count  <= CNT_INIT;
          end
        end
        default: begin
          r_state <= PIN_TURN;
          r_count <= CNT_INIT;
        end
      endcase
    end
  end

  // Pad and function-input muxes; idle/hi-Z unless the pin is active
  always_comb begin
    o_io_out  = 1'b0;
    o_io_oeb  = 1'b1;
    o_func_in = FUNC_IDLE_IN;
    if (r_state == PIN_ACTIVE) begin
      o_io_out            = i_func_out[r_target];
      o_io_oeb            = ~i_func_oe[r_target];
      o_func_in[r_target] = w_sync_q;
    end
  end

  assign o_switching = (r_state == PIN_TURN);
  assign o_target    = r_target;

endmodule

// File: rtl/io_mux_matrix.sv
// Pad multiplexer top: config address decode, readback mux and per-pin bus packing.
module io_mux_matrix
  import io_mux_matrix_pkg::*;
#(
  parameter int unsigned PIN_COUNT   = 38,
  parameter int unsigned FUNC_COUNT  = 4,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TURNAROUND  = 4,
  parameter logic [PIN_COUNT*SEL_WIDTH-1:0] DEFAULT_SEL  = '0,
  parameter logic [FUNC_COUNT-1:0]          FUNC_IDLE_IN = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_we,
  input  logic [CFG_ADDR_W-1:0]           cfg_addr,
  input  logic [SEL_WIDTH-1:0]            cfg_wdata,
  output logic [SEL_WIDTH-1:0]            cfg_rdata,
  output logic [PIN_COUNT-1:0]            pin_switching,
  input  logic [PIN_COUNT*FUNC_COUNT-1:0] func_out,
  input  logic [PIN_COUNT*FUNC_COUNT-1:0] func_oe,
  output logic [PIN_COUNT*FUNC_COUNT-1:0] func_in,
  input  logic [PIN_COUNT-1:0]            io_in,
  output logic [PIN_COUNT-1:0]            io_out,
  output logic [PIN_COUNT-1:0]            io_oeb
);

  logic                 w_addr_ok;
  logic [SEL_WIDTH-1:0] w_wsel;
  logic [SEL_WIDTH-1:0] w_target [PIN_COUNT];

  // Out-of-range pins are ignored; out-of-range functions fall back to GPIO
  assign w_addr_ok = (32'(cfg_addr) < PIN_COUNT);
  assign w_wsel    = (32'(cfg_wdata) < FUNC_COUNT) ? cfg_wdata : '0;

  // Per-pin instances with their slices of the packed function buses
  for (genvar p = 0; p < PIN_COUNT; p++) begin : g_pin
    logic w_we;

    assign w_we = cfg_we && w_addr_ok && (cfg_addr == CFG_ADDR_W'(p));

    io_mux_matrix_pin #(
      .FUNC_COUNT   (FUNC_COUNT),
      .SEL_WIDTH    (SEL_WIDTH),
      .SYNC_STAGES  (SYNC_STAGES),
      .TURNAROUND   (TURNAROUND),
      .DEFAULT_SEL  (DEFAULT_SEL[p*SEL_WIDTH +: SEL_WIDTH]),
      .FUNC_IDLE_IN (FUNC_IDLE_IN)
    ) u_pin (
      .clk         (clk),
      .rst         (rst),
      .i_we        (w_we),
      .i_wdata     (w_wsel),
      .o_target    (w_target[p]),
      .o_switching (pin_switching[p]),
      .i_func_out  (func_out[p*FUNC_COUNT +: FUNC_COUNT]),
      .i_func_oe   (func_oe[p*FUNC_COUNT +: FUNC_COUNT]),
      .o_func_in   (func_in[p*FUNC_COUNT +: FUNC_COUNT]),
      .i_io_in     (io_in[p]),
      .o_io_out    (io_out[p]),
      .o_io_oeb    (io_oeb[p])
    );
  end

  // Combinational readback of the addressed pin's target select
  always_comb begin
    cfg_rdata = '0;
    for (int unsigned p = 0; p < PIN_COUNT; p++) begin
      if (w_addr_ok && (cfg_addr == CFG_ADDR_W'(p))) begin
        cfg_rdata = w_target[p];
      end
    end
  end

endmodule
